// File: rtl/axi_sub_comp_arb.sv
// Burst-locked round-robin arbiter sharing one simplex component port among NREQ
// AXI-subordinate requesters; read valids and errors are steered back to the issuer.
module axi_sub_comp_arb #(
  parameter int NREQ  = 2,
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int UW    = 32,
  parameter int IW    = 1,
  parameter int C_LAT = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_dv,
  input  logic [NREQ*AW-1:0]       req_addr,
  input  logic [NREQ-1:0]          req_write,
  input  logic [NREQ*UW-1:0]       req_user,
  input  logic [NREQ*IW-1:0]       req_id,
  input  logic [NREQ*DW-1:0]       req_wdata,
  input  logic [NREQ*(DW/8)-1:0]   req_wstrb,
  input  logic [NREQ*3-1:0]        req_size,
  input  logic [NREQ-1:0]          req_last,
  output logic [NREQ-1:0]          req_hld,
  output logic [DW-1:0]            req_rdata,
  output logic [NREQ-1:0]          req_rd_vld,
  output logic [NREQ-1:0]          req_rd_err,
  output logic [NREQ-1:0]          req_wr_err,
  output logic                     dv,
  output logic [AW-1:0]            addr,
  output logic                     write,
  output logic [UW-1:0]            user,
  output logic [IW-1:0]            id,
  output logic [DW-1:0]            wdata,
  output logic [DW/8-1:0]          wstrb,
  output logic [2:0]               size,
  output logic                     last,
  input  logic                     hld,
  input  logic [DW-1:0]            rdata,
  input  logic                     rd_err,
  input  logic                     wr_err
);
  localparam int BC  = DW / 8;
  localparam int IXW = $clog2(NREQ);

  typedef enum logic {ST_IDLE, ST_LOCKED} st_t;

  st_t            st_q, st_d;
  logic [IXW-1:0] owner_q, owner_d;
  logic [IXW-1:0] rr_q, rr_d;
  logic [IXW-1:0] gnt;
  logic           gnt_found;
  logic           acc;
  logic           rd_acc;
  logic [NREQ-1:0] rd_vld;

  function automatic logic [IXW-1:0] rr_idx(input logic [IXW-1:0] base, input int k);
    int j;
    j = int'(base) + k;
    if (j >= NREQ) j = j - NREQ;
    return j[IXW-1:0];
  endfunction

  // Grant: the owner while a burst is open, otherwise first requester from rr_q onward.
  always_comb begin
    gnt       = rr_q;
    gnt_found = 1'b0;
    if (st_q == ST_LOCKED) begin
      gnt = owner_q;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        if (!gnt_found && req_dv[rr_idx(rr_q, k)]) begin
          gnt       = rr_idx(rr_q, k);
          gnt_found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    dv    = req_dv[gnt];
    write = req_write[gnt];
    last  = req_last[gnt];
    addr  = req_addr[gnt*AW +: AW];
    user  = req_user[gnt*UW +: UW];
    id    = req_id[gnt*IW +: IW];
    wdata = req_wdata[gnt*DW +: DW];
    wstrb = req_wstrb[gnt*BC +: BC];
    size  = req_size[gnt*3 +: 3];
  end

  assign acc    = dv && !hld;
  assign rd_acc = acc && !write;

  always_comb begin
    req_hld      = '1;
    req_hld[gnt] = hld;
    req_wr_err   = '0;
    if (wr_err && acc && write) req_wr_err[gnt] = 1'b1;
  end

  always_comb begin
    st_d    = st_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    if (acc) begin
      if (last) begin
        st_d = ST_IDLE;
        rr_d = (gnt == IXW'(NREQ - 1)) ? '0 : gnt + 1'b1;
      end else if (st_q == ST_IDLE) begin
        st_d    = ST_LOCKED;
        owner_d = gnt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= ST_IDLE;
      owner_q <= '0;
      rr_q    <= '0;
    end else begin
      st_q    <= st_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
    end
  end

  // Read return: tag each accepted read with its grant and delay it to match the component.
  generate
    if (C_LAT == 0) begin : g_nolat
      always_comb begin
        rd_vld = '0;
        if (rd_acc) rd_vld[gnt] = 1'b1;
      end
    end else begin : g_lat
      logic [C_LAT-1:0] vld_q;
      logic [IXW-1:0]   idx_q [C_LAT];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_q <= '0;
          for (int s = 0; s < C_LAT; s++) idx_q[s] <= '0;
        end else begin
          vld_q[0] <= rd_acc;
          idx_q[0] <= gnt;
          for (int s = 1; s < C_LAT; s++) begin
            vld_q[s] <= vld_q[s-1];
            idx_q[s] <= idx_q[s-1];
          end
        end
      end

      always_comb begin
        rd_vld = '0;
        if (vld_q[C_LAT-1]) rd_vld[idx_q[C_LAT-1]] = 1'b1;
      end
    end
  endgenerate

  assign req_rd_vld = rd_vld;
  assign req_rd_err = rd_vld & {NREQ{rd_err}};
  assign req_rdata  = rdata;

endmodule

// File: tb/tb_axi_sub_comp_arb.sv
// Directed bench for axi_sub_comp_arb: three instances (C_LAT 0/1/2) share one stimulus.
module tb_axi_sub_comp_arb;
  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  req_dv, req_write, req_last, req_id;
  logic [63:0] req_addr, req_user, req_wdata;
  logic [7:0]  req_wstrb;
  logic [5:0]  req_size;
  logic        hld, rd_err, wr_err;
  logic [31:0] rdata;

  logic [1:0]  o_hld   [NI];
  logic [31:0] o_rdata [NI];
  logic [1:0]  o_rdvld [NI];
  logic [1:0]  o_rderr [NI];
  logic [1:0]  o_wrerr [NI];
  logic        c_dv    [NI];
  logic [31:0] c_addr  [NI];
  logic        c_write [NI];
  logic [31:0] c_user  [NI];
  logic [0:0]  c_id    [NI];
  logic [31:0] c_wdata [NI];
  logic [3:0]  c_wstrb [NI];
  logic [2:0]  c_size  [NI];
  logic        c_last  [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    axi_sub_comp_arb #(.NREQ(2), .AW(32), .DW(32), .UW(32), .IW(1), .C_LAT(g)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req_dv(req_dv), .req_addr(req_addr), .req_write(req_write), .req_user(req_user),
      .req_id(req_id), .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_size(req_size),
      .req_last(req_last), .req_hld(o_hld[g]), .req_rdata(o_rdata[g]),
      .req_rd_vld(o_rdvld[g]), .req_rd_err(o_rderr[g]), .req_wr_err(o_wrerr[g]),
      .dv(c_dv[g]), .addr(c_addr[g]), .write(c_write[g]), .user(c_user[g]), .id(c_id[g]),
      .wdata(c_wdata[g]), .wstrb(c_wstrb[g]), .size(c_size[g]), .last(c_last[g]),
      .hld(hld), .rdata(rdata), .rd_err(rd_err), .wr_err(wr_err)
    );
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int i, input logic v, input logic w, input logic l,
                     input logic [31:0] a, input logic [31:0] d);
    req_dv[i]            = v;
    req_write[i]         = w;
    req_last[i]          = l;
    req_addr[i*32 +: 32]  = a;
    req_wdata[i*32 +: 32] = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    req_dv    = '0;
    req_write = '0;
    req_last  = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_user  = {32'hCAFE_0001, 32'hBEEF_0000};
    req_id    = 2'b10;
    req_wstrb = 8'hF3;
    req_size  = {3'd2, 3'd1};
    hld       = 1'b0;
    rd_err    = 1'b0;
    wr_err    = 1'b0;
    rdata     = '0;
    #2;
    chk("rst_hld", o_hld[1], 2'b10);
    chk("rst_dv", c_dv[1], 1'b0);
    chk("rst_rdvld0", o_rdvld[0], 2'b00);
    chk("rst_rdvld2", o_rdvld[2], 2'b00);
    chk("rst_rderr1", o_rderr[1], 2'b00);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // single-beat writes from both, tie broken toward requester 0
    drv(0, 1, 1, 1, 32'h1000, 32'h1111_0000);
    drv(1, 1, 1, 1, 32'h2000, 32'h2222_0000);
    #1;
    chk("t1_addr0", c_addr[1], 32'h1000);
    chk("t1_hld0", o_hld[1], 2'b10);
    chk("t1_user0", c_user[1], 32'hBEEF_0000);
    chk("t1_wdata0", c_wdata[1], 32'h1111_0000);
    chk("t1_wstrb0", c_wstrb[1], 4'h3);
    chk("t1_size0", c_size[1], 3'd1);
    chk("t1_id0", c_id[1], 1'b0);
    tick();
    drv(0, 0, 1, 1, 32'h1000, 32'h0);
    #1;
    chk("t1_addr1", c_addr[1], 32'h2000);
    chk("t1_hld1", o_hld[1], 2'b01);
    chk("t1_user1", c_user[1], 32'hCAFE_0001);
    chk("t1_wstrb1", c_wstrb[1], 4'hF);
    chk("t1_id1", c_id[1], 1'b1);
    tick();
    drv(1, 0, 1, 1, 32'h2000, 32'h0);

    // 4-beat burst from req0; req1 joins at beat 2 and must wait
    for (int b = 0; b < 4; b++) begin
      drv(0, 1, 1, (b == 3), 32'h3000 + 32'(4 * b), 32'h3333_0000 + 32'(b));
      if (b >= 1) drv(1, 1, 1, 1, 32'h4000, 32'h4444_0000);
      #1;
      chk("t2_addr", c_addr[1], 32'h3000 + 32'(4 * b));
      chk("t2_hld", o_hld[1], 2'b10);
      chk("t2_last", c_last[1], (b == 3));
      tick();
    end
    drv(0, 0, 1, 0, 32'h0, 32'h0);
    #1;
    chk("t2_next_addr", c_addr[1], 32'h4000);
    chk("t2_next_hld", o_hld[1], 2'b01);
    chk("t2_next_dv", c_dv[1], 1'b1);
    tick();
    drv(1, 0, 1, 1, 32'h0, 32'h0);

    // back-to-back reads, observed at latency 0/1/2
    drv(0, 1, 0, 1, 32'h5000, 32'h0);
    drv(1, 1, 0, 1, 32'h6000, 32'h0);
    #1;
    chk("t3_n_v0", o_rdvld[0], 2'b01);
    chk("t3_n_v1", o_rdvld[1], 2'b00);
    tick();
    drv(0, 0, 0, 1, 32'h0, 32'h0);
    rdata = 32'hA5A5_0000;
    #1;
    chk("t3_n1_v1", o_rdvld[1], 2'b01);
    chk("t3_n1_v0", o_rdvld[0], 2'b10);
    chk("t3_n1_v2", o_rdvld[2], 2'b00);
    chk("t3_n1_rdata", o_rdata[1], 32'hA5A5_0000);
    tick();
    drv(1, 0, 0, 1, 32'h0, 32'h0);
    rdata  = 32'h0000_5A5A;
    rd_err = 1'b1;
    #1;
    chk("t3_n2_v1", o_rdvld[1], 2'b10);
    chk("t3_n2_v2", o_rdvld[2], 2'b01);
    chk("t3_n2_v0", o_rdvld[0], 2'b00);
    chk("t3_n2_err1", o_rderr[1], 2'b10);
    chk("t3_n2_err2", o_rderr[2], 2'b01);
    chk("t3_n2_err0", o_rderr[0], 2'b00);
    chk("t3_n2_rdata", o_rdata[2], 32'h0000_5A5A);
    tick();
    rd_err = 1'b0;
    #1;
    chk("t3_n3_v2", o_rdvld[2], 2'b10);
    chk("t3_n3_v1", o_rdvld[1], 2'b00);
    chk("t3_n3_err2", o_rderr[2], 2'b00);
    tick();

    // component stall inside req1 burst while req0 waits
    drv(1, 1, 1, 0, 32'h7000, 32'h7777_0000);
    #1;
    chk("t4_b1_addr", c_addr[1], 32'h7000);
    tick();
    drv(1, 1, 1, 0, 32'h7004, 32'h7777_0001);
    drv(0, 1, 1, 1, 32'h8000, 32'h8888_0000);
    hld = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("t4_stall_hld", o_hld[1], 2'b11);
      chk("t4_stall_addr", c_addr[1], 32'h7004);
      tick();
    end
    hld = 1'b0;
    #1;
    chk("t4_rel_hld", o_hld[1], 2'b01);
    chk("t4_rel_addr", c_addr[1], 32'h7004);
    tick();
    drv(1, 1, 1, 1, 32'h7008, 32'h7777_0002);
    #1;
    chk("t4_b3_addr", c_addr[1], 32'h7008);
    chk("t4_b3_hld", o_hld[1], 2'b01);
    tick();
    drv(1, 0, 1, 0, 32'h0, 32'h0);
    #1;
    chk("t4_after_addr", c_addr[1], 32'h8000);
    chk("t4_after_hld", o_hld[1], 2'b10);
    tick();
    drv(0, 0, 1, 0, 32'h0, 32'h0);

    // write error steered to req1 for the accepting cycle only
    drv(1, 1, 1, 1, 32'h9000, 32'h9999_0000);
    wr_err = 1'b1;
    #1;
    chk("t6_wrerr", o_wrerr[1], 2'b10);
    chk("t6_rderr", o_rderr[1], 2'b00);
    tick();
    drv(1, 0, 1, 1, 32'h0, 32'h0);
    #1;
    chk("t6_wrerr_gone", o_wrerr[1], 2'b00);
    wr_err = 1'b0;

    // reset while locked with reads in flight
    drv(1, 1, 0, 0, 32'hA000, 32'h0);
    #1;
    chk("t5_addr", c_addr[1], 32'hA000);
    tick();
    drv(1, 0, 0, 0, 32'h0, 32'h0);
    #1;
    chk("t5_pre_v1", o_rdvld[1], 2'b10);
    chk("t5_pre_hld", o_hld[1], 2'b01);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_v1", o_rdvld[1], 2'b00);
    chk("t5_rst_v2", o_rdvld[2], 2'b00);
    chk("t5_rst_hld", o_hld[1], 2'b10);
    tick();
    chk("t5_rst_v2_late", o_rdvld[2], 2'b00);
    tick();
    rst_n = 1'b1;
    drv(0, 1, 1, 1, 32'hB000, 32'h0);
    drv(1, 1, 1, 1, 32'hC000, 32'h0);
    #1;
    chk("t5_tie_addr", c_addr[2], 32'hB000);
    chk("t5_tie_hld", o_hld[2], 2'b10);
    tick();
    drv(0, 0, 1, 1, 32'h0, 32'h0);
    drv(1, 0, 1, 1, 32'h0, 32'h0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
